// File: rtl/combo_lock_ctrl.sv
// rtl/combo_lock_ctrl.sv - sequencing controller for the combination-lock datapath
//
// Accepts one BCD digit per strobe, compares each attempt against a stored
// code, counts consecutive failures, enforces a timed lockout and lets the
// code be reprogrammed while open.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   digit_valid  one-cycle strobe, digit presented
//   digit        BCD digit value
//   prog_req     level request to reprogram (honoured only in OPEN)
//   state        ENTRY=0, OPEN=1, CLOSED=2, LOCKOUT=3, PROG=4
//   unlocked     1 while in OPEN
//   digit_cnt    digits accepted in the current attempt/program sequence
//   fail_cnt     consecutive failed attempts (saturates at MAX_FAILS)
//   err_digit    one-cycle pulse for a rejected (>9) digit
module combo_lock_ctrl #(
   parameter int                      NUM_DIGITS     = 6,
   parameter int                      MAX_FAILS      = 3,
   parameter int                      LOCKOUT_CYCLES = 16,
   parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE   = 24'h797773
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       prog_req,
   output logic [2:0] state,
   output logic       unlocked,
   output logic [2:0] digit_cnt,
   output logic [3:0] fail_cnt,
   output logic       err_digit
);

   localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
   localparam int CW = 4 * NUM_DIGITS;

   typedef enum logic [2:0] {
      ST_ENTRY   = 3'd0,
      ST_OPEN    = 3'd1,
      ST_CLOSED  = 3'd2,
      ST_LOCKOUT = 3'd3,
      ST_PROG    = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      digit_cnt_q, digit_cnt_d;
   logic [3:0]      fail_cnt_q, fail_cnt_d;
   logic            err_digit_q, err_digit_d;
   logic            unlocked_q, unlocked_d;
   logic            mismatch_q, mismatch_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [CW-1:0]   code_q, code_d;
   logic [CW-1:0]   shadow_q, shadow_d;

   logic [3:0]      exp_nib;
   logic            digit_ok;
   logic            last_digit;
   logic            any_mismatch;
   logic [CW-1:0]   shadow_next;

   // Code nibble for the current position; position 0 is the MSB nibble.
   always_comb begin
      exp_nib = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_cnt_q == 3'(i)) begin
            exp_nib = code_q[4*(NUM_DIGITS-1-i) +: 4];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      digit_cnt_d  = digit_cnt_q;
      fail_cnt_d   = fail_cnt_q;
      err_digit_d  = 1'b0;
      mismatch_d   = mismatch_q;
      timer_d      = timer_q;
      code_d       = code_q;
      shadow_d     = shadow_q;
      digit_ok     = (digit <= 4'd9);
      last_digit   = (digit_cnt_q == 3'(NUM_DIGITS - 1));
      any_mismatch = mismatch_q | (digit != exp_nib);
      shadow_next  = {shadow_q[CW-5:0], digit};

      case (state_q)
         // CLOSED always has digit_cnt=0 and mismatch=0, so its first digit
         // goes through exactly the same path as ENTRY digit 0.
         ST_ENTRY, ST_CLOSED: begin
            if (digit_valid) begin
               if (!digit_ok) begin
                  err_digit_d = 1'b1;
               end else begin
                  state_d = ST_ENTRY;
                  if (last_digit) begin
                     digit_cnt_d = '0;
                     mismatch_d  = 1'b0;
                     if (!any_mismatch) begin
                        state_d    = ST_OPEN;
                        fail_cnt_d = '0;
                     end else if (fail_cnt_q >= 4'(MAX_FAILS - 1)) begin
                        state_d    = ST_LOCKOUT;
                        fail_cnt_d = 4'(MAX_FAILS);
                        timer_d    = TW'(LOCKOUT_CYCLES);
                     end else begin
                        state_d    = ST_CLOSED;
                        fail_cnt_d = fail_cnt_q + 4'd1;
                     end
                  end else begin
                     digit_cnt_d = digit_cnt_q + 3'd1;
                     mismatch_d  = any_mismatch;
                  end
               end
            end
         end
         ST_OPEN: begin
            // A relocking strobe is discarded, whatever its value.
            if (prog_req) begin
               state_d     = ST_PROG;
               digit_cnt_d = '0;
            end else if (digit_valid) begin
               state_d = ST_ENTRY;
            end
         end
         ST_PROG: begin
            if (digit_valid) begin
               if (!digit_ok) begin
                  err_digit_d = 1'b1;
               end else begin
                  shadow_d = shadow_next;
                  if (last_digit) begin
                     code_d      = shadow_next;
                     state_d     = ST_ENTRY;
                     digit_cnt_d = '0;
                  end else begin
                     digit_cnt_d = digit_cnt_q + 3'd1;
                  end
               end
            end
         end
         ST_LOCKOUT: begin
            // <=1 rather than ==1 so a zero timer can never wedge the lock.
            if (timer_q <= TW'(1)) begin
               state_d    = ST_ENTRY;
               fail_cnt_d = '0;
               timer_d    = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: begin
            state_d     = ST_ENTRY;
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
         end
      endcase

      unlocked_d = (state_d == ST_OPEN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_ENTRY;
         digit_cnt_q <= '0;
         fail_cnt_q  <= '0;
         err_digit_q <= 1'b0;
         unlocked_q  <= 1'b0;
         mismatch_q  <= 1'b0;
         timer_q     <= '0;
         code_q      <= DEFAULT_CODE;
         shadow_q    <= '0;
      end else begin
         state_q     <= state_d;
         digit_cnt_q <= digit_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         err_digit_q <= err_digit_d;
         unlocked_q  <= unlocked_d;
         mismatch_q  <= mismatch_d;
         timer_q     <= timer_d;
         code_q      <= code_d;
         shadow_q    <= shadow_d;
      end
   end

   assign state     = state_q;
   assign unlocked  = unlocked_q;
   assign digit_cnt = digit_cnt_q;
   assign fail_cnt  = fail_cnt_q;
   assign err_digit = err_digit_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb/tb_combo_lock_ctrl.sv - self-checking bench for combo_lock_ctrl
module tb_combo_lock_ctrl;

   localparam int          N   = 6;
   localparam int          MF  = 3;
   localparam int          LC  = 16;
   localparam logic [23:0] DEF = 24'h797773;

   localparam int S_ENTRY = 0, S_OPEN = 1, S_CLOSED = 2, S_LOCKOUT = 3, S_PROG = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       digit_valid;
   logic [3:0] digit;
   logic       prog_req;
   logic [2:0] state;
   logic       unlocked;
   logic [2:0] digit_cnt;
   logic [3:0] fail_cnt;
   logic       err_digit;

   combo_lock_ctrl #(
      .NUM_DIGITS(N), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC), .DEFAULT_CODE(DEF)
   ) dut (
      .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
      .prog_req(prog_req), .state(state), .unlocked(unlocked),
      .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .err_digit(err_digit)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: attempts kept as lists of digits, compared as a whole.
   int m_state;
   int m_fail;
   int m_err;
   int m_lock;
   int m_code[N];
   int m_att[$];
   int m_prog[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic dv, input logic [3:0] d, input logic pr);
      bit match;
      if (r) begin
         logic [23:0] def_v;
         def_v   = DEF;
         m_state = S_ENTRY;
         m_fail  = 0;
         m_err   = 0;
         m_lock  = 0;
         m_att.delete();
         m_prog.delete();
         for (int i = 0; i < N; i++) m_code[i] = int'(def_v[4*(N-1-i) +: 4]);
         return;
      end
      m_err = 0;
      case (m_state)
         S_ENTRY, S_CLOSED: if (dv) begin
            if (d > 9) m_err = 1;
            else begin
               m_att.push_back(int'(d));
               m_state = S_ENTRY;
               if (m_att.size() == N) begin
                  match = 1;
                  for (int i = 0; i < N; i++) if (m_att[i] != m_code[i]) match = 0;
                  m_att.delete();
                  if (match) begin
                     m_state = S_OPEN;
                     m_fail  = 0;
                  end else begin
                     m_fail++;
                     if (m_fail >= MF) begin
                        m_state = S_LOCKOUT;
                        m_lock  = LC;
                     end else m_state = S_CLOSED;
                  end
               end
            end
         end
         S_OPEN: begin
            if (pr) begin
               m_state = S_PROG;
               m_prog.delete();
            end else if (dv) m_state = S_ENTRY;
         end
         S_PROG: if (dv) begin
            if (d > 9) m_err = 1;
            else begin
               m_prog.push_back(int'(d));
               if (m_prog.size() == N) begin
                  for (int i = 0; i < N; i++) m_code[i] = m_prog[i];
                  m_prog.delete();
                  m_state = S_ENTRY;
               end
            end
         end
         S_LOCKOUT: begin
            if (m_lock == 1) begin
               m_state = S_ENTRY;
               m_fail  = 0;
               m_lock  = 0;
            end else m_lock--;
         end
         default: m_state = S_ENTRY;
      endcase
   endtask

   task automatic check_outputs();
      int exp_cnt;
      exp_cnt = (m_state == S_PROG) ? m_prog.size() : m_att.size();
      chk("state", 32'(state), 32'(m_state));
      chk("unlocked", 32'(unlocked), 32'(m_state == S_OPEN));
      chk("digit_cnt", 32'(digit_cnt), 32'(exp_cnt));
      chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
      chk("err_digit", 32'(err_digit), 32'(m_err));
   endtask

   task automatic cycle(input logic r, input logic dv, input logic [3:0] d, input logic pr);
      reset       = r;
      digit_valid = dv;
      digit       = d;
      prog_req    = pr;
      @(posedge clk);
      model_edge(r, dv, d, pr);
      #1;
      check_outputs();
   endtask

   task automatic enter(input logic [23:0] c);
      for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, c[4*(N-1-i) +: 4], 1'b0);
   endtask

   initial begin
      int n;
      logic [23:0] seq;
      logic [3:0]  d;
      reset = 1'b1; digit_valid = 1'b0; digit = 4'd0; prog_req = 1'b0;

      // Reset state, then correct code with a strobe every second cycle.
      cycle(1'b1, 1'b0, 4'd0, 1'b0);
      chk("rst_state", 32'(state), 32'(S_ENTRY));
      chk("rst_cnt", 32'(digit_cnt), 32'd0);
      seq = 24'h797773;
      for (int k = 1; k <= N; k++) begin
         cycle(1'b0, 1'b1, seq[4*(N-k) +: 4], 1'b0);
         chk("t1_cnt", 32'(digit_cnt), 32'(k % N));
         cycle(1'b0, 1'b0, 4'd0, 1'b0);
      end
      chk("t1_open", 32'(state), 32'(S_OPEN));
      chk("t1_unlocked", 32'(unlocked), 32'd1);

      // Relock, rejected digit, wrong attempt.
      cycle(1'b0, 1'b1, 4'd5, 1'b0);
      chk("t6_relock", 32'(state), 32'(S_ENTRY));
      chk("t6_noerr", 32'(err_digit), 32'd0);
      cycle(1'b0, 1'b1, 4'hF, 1'b0);
      chk("t2_err", 32'(err_digit), 32'd1);
      chk("t2_cnt", 32'(digit_cnt), 32'd0);
      cycle(1'b0, 1'b0, 4'd0, 1'b0);
      chk("t2_err_pulse", 32'(err_digit), 32'd0);
      enter(24'h793235);
      chk("t2_closed", 32'(state), 32'(S_CLOSED));
      chk("t2_fail", 32'(fail_cnt), 32'd1);

      // Three wrong attempts -> lockout of exactly LC cycles.
      cycle(1'b1, 1'b0, 4'd0, 1'b0);
      for (int a = 0; a < 3; a++) enter(24'h793235);
      chk("t3_lock", 32'(state), 32'(S_LOCKOUT));
      chk("t3_fail", 32'(fail_cnt), 32'd3);
      n = 1;
      for (int c = 0; c < 40; c++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if (state == 3'(S_LOCKOUT)) n++;
         else break;
      end
      chk("t3_lock_len", 32'(n), 32'(LC));
      chk("t3_entry", 32'(state), 32'(S_ENTRY));
      chk("t3_fail_clr", 32'(fail_cnt), 32'd0);

      // Reprogram to 123456.
      enter(24'h797773);
      chk("t4_open", 32'(state), 32'(S_OPEN));
      cycle(1'b0, 1'b0, 4'd0, 1'b1);
      chk("t4_prog", 32'(state), 32'(S_PROG));
      cycle(1'b0, 1'b1, 4'd1, 1'b1);
      for (int k = 2; k <= N; k++) cycle(1'b0, 1'b1, 4'(k), 1'b0);
      chk("t4_entry", 32'(state), 32'(S_ENTRY));
      enter(24'h797773);
      chk("t4_old_rejected", 32'(state), 32'(S_CLOSED));
      enter(24'h123456);
      chk("t4_new_open", 32'(state), 32'(S_OPEN));

      // prog_req wins over digit_valid; then reprogram to 654321.
      cycle(1'b0, 1'b1, 4'd9, 1'b1);
      chk("t6_prog", 32'(state), 32'(S_PROG));
      chk("t6_prog_cnt", 32'(digit_cnt), 32'd0);
      enter(24'h654321);
      enter(24'h654321);
      chk("t6_open", 32'(state), 32'(S_OPEN));
      cycle(1'b0, 1'b1, 4'd0, 1'b0);
      chk("t6_unlocked", 32'(unlocked), 32'd0);

      // Reset mid-attempt restores the default code.
      cycle(1'b0, 1'b1, 4'd7, 1'b0);
      cycle(1'b0, 1'b1, 4'd9, 1'b0);
      cycle(1'b0, 1'b1, 4'd7, 1'b0);
      cycle(1'b1, 1'b0, 4'd0, 1'b0);
      chk("t5_state", 32'(state), 32'(S_ENTRY));
      chk("t5_cnt", 32'(digit_cnt), 32'd0);
      chk("t5_fail", 32'(fail_cnt), 32'd0);
      enter(24'h797773);
      chk("t5_default", 32'(state), 32'(S_OPEN));

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if ((m_state == S_ENTRY || m_state == S_CLOSED) && r < 60)
            d = 4'(m_code[m_att.size()]);
         else if (r < 80)
            d = 4'($urandom_range(0, 15));
         else
            d = 4'($urandom_range(0, 9));
         cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), d,
               1'($urandom_range(0, 9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
